// File: rtl/fprint_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fprint_bus_arbiter_if                                        |
// | Description : Requester-side and comparator-side signal bundle of the      |
// |               fingerprint write-port arbiter. The arbiter connects through |
// |               the master modport; the surrounding cores and the            |
// |               comparator connect through the slave modport.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fprint_bus_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    // Requester side: one write channel per physical core
    logic [NUM_REQ-1:0]            req_write;
    logic [4*NUM_REQ-1:0]          req_offset;
    logic [DATA_WIDTH*NUM_REQ-1:0] req_writedata;
    logic [NUM_REQ-1:0]            req_waitrequest;

    // Comparator side: the single shared write port
    logic [7:0]                    fprint_address;
    logic                          fprint_write;
    logic [DATA_WIDTH-1:0]         fprint_writedata;
    logic                          fprint_waitrequest;

    // Status
    logic                          arb_busy;
    logic [3:0]                    arb_grant_idx;

    modport master (
        input  req_write, req_offset, req_writedata, fprint_waitrequest,
        output req_waitrequest, fprint_address, fprint_write, fprint_writedata,
        output arb_busy, arb_grant_idx
    );

    modport slave (
        output req_write, req_offset, req_writedata, fprint_waitrequest,
        input  req_waitrequest, fprint_address, fprint_write, fprint_writedata,
        input  arb_busy, arb_grant_idx
    );
endinterface
`default_nettype wire

// File: rtl/fprint_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fprint_bus_arbiter                                           |
// | Description : Round-robin arbiter sharing one fingerprint comparator write |
// |               port between NUM_REQ core fingerprint units. The granted     |
// |               index is inserted as core id in address[7:4].                |
// |               Optional macro FPRINT_ARB_BLOCK_LOCK_EN keeps the port       |
// |               locked to one core between the two CRC halves.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fprint_bus_arbiter #(
    parameter int         NUM_REQ    = 4,     // 2..16 requesters
    parameter int         DATA_WIDTH = 32,    // must be >= 6 (bit 5 marks CRC half)
    parameter logic [3:0] CRC_OFFSET = 4'h4
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    fprint_bus_arbiter_if.master bus
);

`ifdef FPRINT_ARB_BLOCK_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_rr;          // index of the last completed (unlocked) grant
    logic                r_lock;
    logic [3:0]          r_lock_idx;

    logic [15:0]         w_req16;       // requests zero-extended to the full 4-bit id space
    logic [15:0]         w_elig;
    logic [4:0]          w_cand;
    logic                w_found;
    logic [3:0]          w_win;
    logic [3:0]          w_sel_offset;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM_REQ-1:0]  w_done_mask;
    logic                w_is_crc;
    logic                w_lock_set;
    logic                w_lock_clr;

    assign w_req16 = 16'(bus.req_write);

    // While locked only the owner of the open fingerprint may win
    always_comb begin
        w_elig = w_req16;
        if (r_lock) begin
            w_elig = w_req16 & (16'd1 << r_lock_idx);
        end
    end

    // Round-robin search starting just after the last granted index, with wrap
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr} + 5'(k);
            if (w_cand >= 5'(NUM_REQ)) begin
                w_cand = w_cand - 5'(NUM_REQ);
            end
            if (!w_found && w_elig[w_cand[3:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[3:0];
            end
        end
    end

    // Mux the winner's offset and data out of the flattened request buses
    always_comb begin
        w_sel_offset = '0;
        w_sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 4'(i)) begin
                w_sel_offset = bus.req_offset[4*i +: 4];
                w_sel_data   = bus.req_writedata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Completion handshake drops only the waitrequest of the current grant
    always_comb begin
        w_done_mask = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.arb_grant_idx == 4'(i)) begin
                w_done_mask[i] = 1'b0;
            end
        end
    end

    // Lock decisions look at the latched copy of the transfer being completed
    assign w_is_crc   = (bus.fprint_address[3:0] == CRC_OFFSET);
    assign w_lock_set = LOCK_EN && !r_lock && w_is_crc && !bus.fprint_writedata[5];
    assign w_lock_clr = LOCK_EN &&  r_lock && (bus.fprint_writedata[5] || !w_is_crc);

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state              <= S_IDLE;
            r_rr                 <= 4'(NUM_REQ - 1);
            r_lock               <= 1'b0;
            r_lock_idx           <= '0;
            bus.req_waitrequest  <= '1;
            bus.fprint_write     <= 1'b0;
            bus.fprint_address   <= '0;
            bus.fprint_writedata <= '0;
            bus.arb_busy         <= 1'b0;
            bus.arb_grant_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        bus.arb_grant_idx    <= w_win;
                        bus.fprint_address   <= {w_win, w_sel_offset};
                        bus.fprint_writedata <= w_sel_data;
                        bus.fprint_write     <= 1'b1;
                        bus.arb_busy         <= 1'b1;
                        r_state              <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.fprint_waitrequest) begin
                        bus.fprint_write    <= 1'b0;
                        bus.req_waitrequest <= w_done_mask;
                        r_state             <= S_DONE;
                        // The pointer is frozen while a fingerprint pair is open
                        if (w_lock_set) begin
                            r_lock     <= 1'b1;
                            r_lock_idx <= bus.arb_grant_idx;
                        end else if (w_lock_clr) begin
                            r_lock     <= 1'b0;
                            r_rr       <= bus.arb_grant_idx;
                        end else if (!r_lock) begin
                            r_rr       <= bus.arb_grant_idx;
                        end
                    end
                end
                S_DONE: begin
                    bus.req_waitrequest <= '1;
                    bus.arb_busy        <= 1'b0;
                    r_state             <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fprint_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fprint_bus_arbiter                                        |
// | Description : Self-checking bench for fprint_bus_arbiter: transaction-level|
// |               reference model checked every cycle, directed scenarios with |
// |               literal expectations, randomized requesters, and a 16-core   |
// |               instance for the id-wrap boundary.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fprint_bus_arbiter;
    localparam int         N   = 4;
    localparam int         DW  = 32;
    localparam logic [3:0] CRC = 4'h4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fprint_bus_arbiter_if #(.NUM_REQ(N),  .DATA_WIDTH(DW)) bus();
    fprint_bus_arbiter_if #(.NUM_REQ(16), .DATA_WIDTH(DW)) bus16();

    fprint_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CRC_OFFSET(CRC)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    fprint_bus_arbiter #(.NUM_REQ(16), .DATA_WIDTH(DW), .CRC_OFFSET(CRC)) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    // Expected outputs after the most recent rising edge.
    logic [N-1:0]  exp_wait;
    logic          exp_write, exp_busy;
    logic [7:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_grant;
    int            m_phase;     // 0 no transfer, 1 on comparator port, 2 handshake ending
    int            m_last;      // last index whose turn counted for fairness
    bit            m_open;      // a first CRC half is outstanding
    int            m_owner;
    int            m_g;
    logic [3:0]    m_off;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        exp_wait = '1; exp_write = 1'b0; exp_busy = 1'b0;
        exp_addr = '0; exp_data = '0; exp_grant = '0;
        m_phase = 0; m_last = N - 1; m_open = 1'b0; m_owner = 0; m_g = 0;
        m_off = '0; m_data = '0;
    endtask

    task automatic model_step();
        int w;
        case (m_phase)
            0: begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (w < 0 && ((bus.req_write >> j) & 1) != 0 && (!m_open || j == m_owner))
                        w = j;
                end
                if (w >= 0) begin
                    m_g = w;
                    m_off  = 4'(bus.req_offset >> (4 * w));
                    m_data = DW'(bus.req_writedata >> (DW * w));
                    exp_write = 1'b1; exp_busy = 1'b1; exp_grant = 4'(w);
                    exp_addr = {4'(w), m_off}; exp_data = m_data;
                    m_phase = 1;
                end
            end
            1: begin
                if (!bus.fprint_waitrequest) begin
                    exp_write = 1'b0;
                    exp_wait  = ~(N'(1) << m_g);
                    m_phase   = 2;
`ifdef FPRINT_ARB_BLOCK_LOCK_EN
                    if (!m_open && m_off == CRC && !m_data[5]) begin
                        m_open = 1'b1; m_owner = m_g;
                    end else if (m_open) begin
                        if (m_data[5] || m_off != CRC) begin
                            m_open = 1'b0; m_last = m_g;
                        end
                    end else begin
                        m_last = m_g;
                    end
`else
                    m_last = m_g;
`endif
                end
            end
            default: begin
                exp_wait = '1; exp_busy = 1'b0; m_phase = 0;
            end
        endcase
    endtask

    // Inputs change only at negedge+1, so at each negedge they still equal
    // what the DUT sampled on the preceding rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            else          model_step();
            check("req_waitrequest", 64'(bus.req_waitrequest), 64'(exp_wait));
            check("fprint_write", 64'(bus.fprint_write), 64'(exp_write));
            check("arb_busy", 64'(bus.arb_busy), 64'(exp_busy));
            check("arb_grant_idx", 64'(bus.arb_grant_idx), 64'(exp_grant));
            if (exp_write) begin
                check("fprint_address", 64'(bus.fprint_address), 64'(exp_addr));
                check("fprint_writedata", 64'(bus.fprint_writedata), 64'(exp_data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        bus.req_write = '0; bus.req_offset = '0; bus.req_writedata = '0;
        bus.fprint_waitrequest = 1'b1;
        bus16.req_write = '0; bus16.req_offset = '0; bus16.req_writedata = '0;
        bus16.fprint_waitrequest = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_write(input string nm, input logic lvl);
        int t;
        t = 0;
        while (bus.fprint_write !== lvl && t < 50) begin
            tick();
            t++;
        end
        if (bus.fprint_write !== lvl) timeout(nm);
    endtask

    task automatic wait_write16(input string nm);
        int t;
        t = 0;
        while (bus16.fprint_write !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (bus16.fprint_write !== 1'b1) timeout(nm);
    endtask

    logic [3:0] got[8];
    int         ng;
    logic       prev_w;
    int         c0;
    logic [3:0] exp_rr[5];
    logic [3:0] exp_lk[3];

    initial begin
        bus.req_write = '0; bus.req_offset = '0; bus.req_writedata = '0;
        bus.fprint_waitrequest = 1'b1;
        bus16.req_write = '0; bus16.req_offset = '0; bus16.req_writedata = '0;
        bus16.fprint_waitrequest = 1'b1;
        do_reset();
        check("reset_waitreq", 64'(bus.req_waitrequest), 64'h000F);
        check("reset_write", 64'(bus.fprint_write), 64'h0);

        // 1: single request, held off three cycles by the comparator
        bus.req_write = 4'b0100;
        bus.req_offset[11:8] = 4'h4;
        bus.req_writedata[2*DW +: DW] = 32'hABCD0000;
        tick();
        check("t1_addr", 64'(bus.fprint_address), 64'h24);
        check("t1_write", 64'(bus.fprint_write), 64'h1);
        check("t1_data", 64'(bus.fprint_writedata), 64'hABCD0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t1_hold", 64'(bus.fprint_write), 64'h1);
        end
        bus.fprint_waitrequest = 1'b0;
        tick();
        check("t1_done_wait", 64'(bus.req_waitrequest), 64'b1011);
        check("t1_done_write", 64'(bus.fprint_write), 64'h0);
        bus.req_write = '0;
        tick();
        check("t1_wait_back", 64'(bus.req_waitrequest), 64'b1111);

        // 2: all cores request continuously
        do_reset();
        bus.req_write = 4'b1111;
        bus.fprint_waitrequest = 1'b0;
        exp_rr[0] = 4'd0; exp_rr[1] = 4'd1; exp_rr[2] = 4'd2; exp_rr[3] = 4'd3; exp_rr[4] = 4'd0;
        for (int k = 0; k < 5; k++) begin
            wait_write("t2_grant_wait", 1'b1);
            check("t2_rr_order", 64'(bus.fprint_address[7:4]), 64'(exp_rr[k]));
            wait_write("t2_release_wait", 1'b0);
        end
        bus.req_write = '0;

        // 3: requester data changes are ignored once granted
        do_reset();
        bus.req_write = 4'b0010;
        bus.req_writedata[DW +: DW] = 32'h1;
        wait_write("t3_grant_wait", 1'b1);
        bus.req_writedata[DW +: DW] = 32'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stable_data", 64'(bus.fprint_writedata), 64'h1);
        end
        bus.fprint_waitrequest = 1'b0;
        tick();
        check("t3_done", 64'(bus.req_waitrequest), 64'b1101);
        bus.req_write = '0;

        // 4: both CRC halves from core 0 versus a competing core 3
        do_reset();
`ifdef FPRINT_ARB_BLOCK_LOCK_EN
        exp_lk[0] = 4'd0; exp_lk[1] = 4'd0; exp_lk[2] = 4'd3;
`else
        exp_lk[0] = 4'd0; exp_lk[1] = 4'd3; exp_lk[2] = 4'd0;
`endif
        bus.fprint_waitrequest = 1'b0;
        bus.req_offset[3:0] = CRC;
        bus.req_writedata[0 +: DW] = 32'h1000_0000;
        bus.req_offset[15:12] = 4'h0;
        bus.req_writedata[3*DW +: DW] = 32'h33;
        bus.req_write = 4'b1001;
        ng = 0; prev_w = 1'b0; c0 = 0;
        for (int t = 0; t < 60 && (ng < 3 || bus.req_write != 0); t++) begin
            tick();
            if (bus.fprint_write && !prev_w && ng < 8) begin
                got[ng] = bus.fprint_address[7:4];
                ng++;
            end
            prev_w = bus.fprint_write;
            if (!bus.req_waitrequest[0]) begin
                c0++;
                if (c0 == 1) bus.req_writedata[0 +: DW] = 32'h0000_0020;
                else         bus.req_write[0] = 1'b0;
            end
            if (!bus.req_waitrequest[3]) bus.req_write[3] = 1'b0;
        end
        if (ng < 3) timeout("t4_grants");
        else for (int k = 0; k < 3; k++) check("t4_lock_order", 64'(got[k]), 64'(exp_lk[k]));
        bus.req_write = '0;

        // Randomized requesters against the reference model
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (bus.req_write[i] && !bus.req_waitrequest[i]) begin
                    bus.req_write[i] = 1'($urandom_range(0, 1));
                    bus.req_offset[4*i +: 4] = ($urandom_range(0, 1) == 1) ? CRC : 4'($urandom);
                    bus.req_writedata[DW*i +: DW] = $urandom;
                end else if (!bus.req_write[i]) begin
                    bus.req_write[i] = ($urandom_range(0, 3) == 0);
                    bus.req_offset[4*i +: 4] = ($urandom_range(0, 1) == 1) ? CRC : 4'($urandom);
                    bus.req_writedata[DW*i +: DW] = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req_writedata[DW*i +: DW] = $urandom;
                end
            end
            bus.fprint_waitrequest = 1'($urandom_range(0, 1));
        end

        // 5: asynchronous reset in the middle of a transfer
        do_reset();
        bus.req_write = 4'b1111;
        bus.fprint_waitrequest = 1'b1;
        wait_write("t5_grant_wait", 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_write", 64'(bus.fprint_write), 64'h0);
        check("t5_async_wait", 64'(bus.req_waitrequest), 64'b1111);
        check("t5_async_busy", 64'(bus.arb_busy), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_first_grant", 64'(bus.arb_grant_idx), 64'h0);
        check("t5_first_write", 64'(bus.fprint_write), 64'h1);
        bus.req_write = '0;

        // 6: sixteen cores, highest id and wrap back to zero
        do_reset();
        bus16.fprint_waitrequest = 1'b0;
        bus16.req_write = 16'h8000;
        wait_write16("t6_grant15_wait");
        check("t6_addr_hi", 64'(bus16.fprint_address[7:4]), 64'hF);
        tick();
        check("t6_done15", 64'(bus16.req_waitrequest), 64'h7FFF);
        bus16.req_write = 16'h8001;
        tick();
        tick();
        wait_write16("t6_grant0_wait");
        check("t6_wrap_to_0", 64'(bus16.fprint_address[7:4]), 64'h0);
        bus16.req_write = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fprint_bus_arbiter.md
Name: fprint_bus_arbiter

Overview:
- Shares the single fingerprint/comparator write port (address, write, writedata, waitrequest) between NUM_REQ physical-core fingerprint units.
- Each requester presents a 4-bit register offset and 32-bit writedata.
- The arbiter picks requesters round-robin and inserts the requester index as physical core id in address[7:4].
- It holds the comparator write until waitrequest drops, then completes the requester's own handshake.

Parameters:
NUM_REQ, 4, number of requesting cores (2..16)
DATA_WIDTH, 32, write data width
CRC_OFFSET, 4'h4, address[3:0] offset of the CRC (fingerprint) register

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_write  in  NUM_REQ  per-requester write request, held until its waitrequest is low
req_offset  in  4*NUM_REQ  per-requester register offset, slice i = [4i+3:4i]
req_writedata  in  DATA_WIDTH*NUM_REQ  per-requester data, slice i
req_waitrequest  out  NUM_REQ  per-requester waitrequest, low for exactly one cycle on completion
fprint_address  out  8  {grant index[3:0], offset[3:0]} to comparator
fprint_write  out  1  write strobe to comparator
fprint_writedata  out  DATA_WIDTH  data to comparator
fprint_waitrequest  in  1  comparator waitrequest; a transfer completes when fprint_write=1 and fprint_waitrequest=0
arb_busy  out  1  high while in ISSUE or DONE
arb_grant_idx  out  4  index of current/last grant

Behaviour:
- All outputs are registered.
- Reset (reset_n=0, async) sets:
  - req_waitrequest to all ones.
  - fprint_write=0, fprint_address=0, fprint_writedata=0.
  - arb_busy=0, arb_grant_idx=0, rr pointer=NUM_REQ-1, lock=0.
  - State to IDLE.
- Reset mid-transfer drops fprint_write immediately. No completion is reported and no state is retained.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any req_write[i]=1, select the winner and latch its index, offset and data into the output registers.
  - Drive fprint_write=1 next cycle and go to ISSUE.
  - Latency: request seen in cycle N, fprint_write high in cycle N+1.
- Winner selection:
  - If lock is set, only the locked index is eligible; other requests wait.
  - Otherwise round-robin: first asserted index searching from (rr pointer+1) mod NUM_REQ upward with wrap.
- ISSUE:
  - Hold fprint_address, fprint_write and fprint_writedata stable.
  - When fprint_waitrequest=0, deassert fprint_write, drive req_waitrequest[grant]=0 for one cycle, update rr pointer := grant, and go to DONE.
  - No timeout; the arbiter waits indefinitely.
- DONE:
  - req_waitrequest returns to all ones; return to IDLE.
  - A requester may drop or re-present req_write in this cycle.
  - The earliest next grant is taken in IDLE, giving a minimum 3-cycle issue spacing.
- Requests do not need to be stable before grant. After grant, the arbiter uses only the latched copy; requester changes during ISSUE are ignored.
- Simultaneous requests are resolved by the round-robin order above. A requester with req_write held continuously gets at most one grant per full rotation while others request.
- A requester index is never granted while its own previous transfer is in ISSUE/DONE; only one transfer is outstanding at a time.
- NUM_REQ<16: address[7:4] is the zero-extended index.

Optional Feature:
Macro FPRINT_ARB_BLOCK_LOCK_EN.
- Defined:
  - Lock set: on completion of a write with offset==CRC_OFFSET and writedata[5]==0 (first fingerprint half), lock:=1 and the locked index := grant.
  - Lock cleared: on completion of any write from the locked index with writedata[5]==1, or with offset!=CRC_OFFSET.
  - While locked, other requesters are not granted, so both halves of a fingerprint reach the comparator back-to-back.
  - The rr pointer advances only when lock clears.
- Not defined: lock is held at 0; pure round-robin per transfer.

Test Plan:
1. Single request: req_write[2]=1, offset 4'h4, data 32'hABCD0000 -> next cycle fprint_address=8'h24, fprint_write=1. Hold waitrequest=1 for 3 cycles, then 0 -> req_waitrequest[2] low exactly one cycle, fprint_write low next cycle.
2. Round-robin: after reset, req_write=4'b1111 held, waitrequest low on every ISSUE cycle -> grant order 0,1,2,3,0; fprint_address[7:4] follows; no index granted twice consecutively.
3. Data stability: core 1 changes req_writedata from 32'h1 to 32'h2 during ISSUE with waitrequest=1 -> fprint_writedata remains 32'h1 until completion.
4. Lock (macro defined): core 0 writes CRC offset with bit5=0, core 3 requesting -> core 3 is not granted until core 0's bit5=1 CRC write completes. Sequence 0,0,3.
   - Macro undefined -> sequence 0,3,0.
5. Reset mid-operation: assert reset_n=0 during ISSUE -> fprint_write=0 and req_waitrequest=4'b1111 asynchronously. After release, the first request is granted to index 0 when all request.
6. Boundary: NUM_REQ=16, only req_write[15]=1 -> fprint_address[7:4]=4'hF, then pointer wraps and index 0 is granted next when both 0 and 15 request.
